// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer.
//   op_e        : ALU operation requested by the datapath (AND/OR/ADD/SUB)
//   state_e     : sequencer FSM states
//   SLICE_*     : operation encodings understood by the 1-bit ALU slice
package serial_alu_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam logic [1:0] SLICE_AND = 2'd0;
    localparam logic [1:0] SLICE_OR  = 2'd1;
    localparam logic [1:0] SLICE_ADD = 2'd2;

endpackage

// File: rtl/serial_alu_ctrl_alu_1bit.sv
// One-bit ALU slice: optional operand inversion, then AND / OR / full-add.
// Ports:
//   a_i, b_i        operand bits
//   ainvert_i       invert a_i before the operation
//   binvert_i       invert b_i before the operation
//   cin_i           carry in (used by ADD only)
//   op_i            SLICE_AND / SLICE_OR / SLICE_ADD
//   res_o           result bit
//   cout_o          carry out (0 for the logic operations)
module alu_1bit
    import serial_alu_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    input  logic       ainvert_i,
    input  logic       binvert_i,
    input  logic       cin_i,
    input  logic [1:0] op_i,
    output logic       res_o,
    output logic       cout_o
);

    logic a_eff;
    logic b_eff;

    assign a_eff = a_i ^ ainvert_i;
    assign b_eff = b_i ^ binvert_i;

    always_comb begin
        res_o  = 1'b0;
        cout_o = 1'b0;
        case (op_i)
            SLICE_AND: res_o = a_eff & b_eff;
            SLICE_OR:  res_o = a_eff | b_eff;
            SLICE_ADD: begin
                res_o  = a_eff ^ b_eff ^ cin_i;
                cout_o = (a_eff & b_eff) | (a_eff & cin_i) | (b_eff & cin_i);
            end
            default: begin
                res_o  = 1'b0;
                cout_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer: runs a WIDTH-bit AND/OR/ADD/SUB through one
// alu_1bit slice, LSB first, one bit per clock, then presents the result
// word and flags with a one-cycle done pulse.
// Build option: define SERIAL_ALU_OVF_EN to enable signed-overflow detection;
// without it, overflow is tied to 0.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   start        request, sampled only in IDLE
//   op           00 AND, 01 OR, 10 ADD, 11 SUB (a - b)
//   a, b         operands, latched on the accepted start edge
//   busy         high in RUN and DONE
//   done         one-cycle pulse; result/flags valid from this cycle on
//   result       result word, held until the next done
//   carry_out    final carry for ADD/SUB (1 = no borrow for SUB), 0 otherwise
//   zero         result == 0
//   overflow     signed overflow for ADD/SUB
//
// state   | meaning
// IDLE    | waiting for start
// RUN     | processing one bit per cycle, LSB first
// DONE    | result/flags presented, done asserted
module serial_alu_ctrl
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    // Only WIDTH-1 result bits need storing: the last bit comes straight
    // from the slice on the final RUN edge.
    logic [WIDTH-2:0] res_sh_q, res_sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;

    logic             is_arith;
    logic [1:0]       slice_op;
    logic             slice_res;
    logic             slice_cout;
    logic [WIDTH-1:0] res_full;

    assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);

    always_comb begin
        case (op_q)
            OP_AND:  slice_op = SLICE_AND;
            OP_OR:   slice_op = SLICE_OR;
            default: slice_op = SLICE_ADD;
        endcase
    end

    alu_1bit u_slice (
        .a_i       (a_sh_q[0]),
        .b_i       (b_sh_q[0]),
        .ainvert_i (1'b0),
        .binvert_i (op_q == OP_SUB),
        .cin_i     (carry_q),
        .op_i      (slice_op),
        .res_o     (slice_res),
        .cout_o    (slice_cout)
    );

    assign res_full = {slice_res, res_sh_q};

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = op_e'(op);
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = (op_e'(op) == OP_SUB);
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                res_sh_d = res_full[WIDTH-1:1];
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                carry_d  = is_arith & slice_cout;
                cnt_d    = cnt_q + 1'b1;
                // Results are registered on the last RUN edge so they are
                // already visible in the cycle done is high.
                if (cnt_q == CNT_LAST) begin
                    result_d = res_full;
                    cout_d   = is_arith & slice_cout;
                    zero_d   = (res_full == '0);
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_AND;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

`ifdef SERIAL_ALU_OVF_EN
    // During the last RUN cycle carry_q is the carry into the MSB.
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state_q == ST_RUN && cnt_q == CNT_LAST) begin
            ovf_q <= is_arith & (carry_q ^ slice_cout);
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign result    = result_q;
    assign carry_out = cout_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
module tb_serial_alu_ctrl;

`ifdef SERIAL_ALU_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       carry_out;
    logic       zero;
    logic       overflow;

    serial_alu_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .zero      (zero),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       v;   // signed overflow when detection is enabled
    } vec_t;

    typedef struct {
        string      name;
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       v;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   n_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pops the expectation queued at start.
    always @(negedge clk) begin
        if (rst_n && done) begin
            n_done++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_result"},   32'(result),    32'(e.res));
                chk({e.name, "_carry"},    32'(carry_out), 32'(e.c));
                chk({e.name, "_zero"},     32'(zero),      32'(e.z));
                chk({e.name, "_overflow"}, 32'(overflow),  32'(e.v));
            end
        end
    end

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.name = v.name;
        e.res  = v.res;
        e.c    = v.c;
        e.z    = v.z;
        e.v    = v.v & OVF_ON;
        sb.push_back(e);
    endtask

    // Issue one op, measure done latency from the start edge, check busy.
    task automatic run_op(input vec_t v);
        int cyc;
        @(negedge clk);
        start = 1'b1;
        op    = v.op;
        a     = v.a;
        b     = v.b;
        push_exp(v);
        @(negedge clk);
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        op    = 2'($urandom);
        cyc   = 1;
        chk({v.name, "_busy_rise"}, 32'(busy), 32'd1);
        while (!done && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        chk({v.name, "_latency"}, 32'(cyc), 32'd9);
        @(negedge clk);
        chk({v.name, "_done_pulse"}, 32'(done), 32'd0);
        chk({v.name, "_busy_fall"},  32'(busy), 32'd0);
    endtask

    vec_t vecs[10];

    initial begin
        int   d0;
        logic busy_ok;
        int   cyc;

        vecs[0] = '{"add_ff_01", 2'b10, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{"sub_05_07", 2'b11, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{"sub_07_05", 2'b11, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{"add_7f_01", 2'b10, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{"and_f0_3c", 2'b00, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{"or_f0_0c",  2'b01, 8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{"sub_80_01", 2'b11, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{"sub_00_00", 2'b11, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{"and_0f_f0", 2'b00, 8'h0F, 8'hF0, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[9] = '{"add_80_80", 2'b10, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = 8'h00;
        b     = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_busy",   32'(busy),      32'd0);
        chk("rst_done",   32'(done),      32'd0);
        chk("rst_result", 32'(result),    32'd0);
        chk("rst_carry",  32'(carry_out), 32'd0);
        chk("rst_zero",   32'(zero),      32'd0);
        chk("rst_ovf",    32'(overflow),  32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_op(vecs[i]);

        // start pulsed mid-RUN with different operands must be ignored.
        d0 = n_done;
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 8'h12; b = 8'h34;
        push_exp('{"midrun", 2'b10, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        start = 1'b0;
        busy_ok = busy;
        cyc = 1;
        while (!done && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (cyc == 4) begin
                start = 1'b1; op = 2'b00; a = 8'hFF; b = 8'h00;
            end else begin
                start = 1'b0;
            end
            busy_ok = busy_ok & busy;
        end
        chk("midrun_latency", 32'(cyc), 32'd9);
        chk("midrun_busy_unbroken", 32'(busy_ok), 32'd1);
        repeat (15) @(negedge clk);
        chk("midrun_single_done", 32'(n_done - d0), 32'd1);

        // Reset while bit 4 of an ADD is being processed.
        d0 = n_done;
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 8'h55; b = 8'h0F;
        push_exp('{"rst_mid", 2'b10, 8'h55, 8'h0F, 8'h64, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);   // now in cycle T0+5: bit 4
        rst_n = 1'b0;
        #1;
        chk("midrst_busy",   32'(busy),      32'd0);
        chk("midrst_done",   32'(done),      32'd0);
        chk("midrst_result", 32'(result),    32'd0);
        chk("midrst_carry",  32'(carry_out), 32'd0);
        chk("midrst_zero",   32'(zero),      32'd0);
        chk("midrst_ovf",    32'(overflow),  32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("midrst_no_done", 32'(n_done - d0), 32'd0);

        run_op('{"after_rst", 2'b10, 8'h55, 8'h0F, 8'h64, 1'b0, 1'b0, 1'b0});
        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
